// File: rtl/vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// vga_sync_monitor
//
// Watches the hsync/vsync outputs of a VGA timing generator, measures line
// period, hsync pulse width and frame height, and locks once LOCK_FRAMES
// consecutive frames match the expected geometry. Any bad line or frame while
// locked drops lock and bumps an error counter. A watchdog forces
// re-acquisition when vsync stops.
//
// Optional feature (macro SYNC_MON_COLOR_CHECK_EN): sticky color_err flag set
// when more than one colour input is high in the same cycle. With the macro
// undefined the port does not exist and no colour logic is built.
//
// Parameters:
//   EXP_H_TOTAL  expected clocks per line (hsync fall to hsync fall)
//   EXP_V_TOTAL  expected lines per frame (vsync fall to vsync fall)
//   LOCK_FRAMES  consecutive good frames needed to lock (1..15)
//   TIMEOUT_W    loss of sync after 2^TIMEOUT_W clocks without a vsync fall
//
// Ports:
//   sys_clk            sole clock, rising edge
//   sys_rst            synchronous active-high reset
//   hsync, vsync       active-low sync inputs
//   red, green, blue   colour inputs
//   locked             high while in LOCKED
//   frame_tick         one-cycle pulse per detected vsync fall
//   h_total            last measured line period (clocks)
//   h_pulse            last measured hsync low width (clocks)
//   v_total            last measured frame height (lines)
//   err_cnt            bad frames seen while locked, saturating at 255
//   color_err          sticky colour-overlap flag (macro builds only)
// -----------------------------------------------------------------------------
module vga_sync_monitor #(
  parameter int EXP_H_TOTAL = 713,
  parameter int EXP_V_TOTAL = 629,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT_W   = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output logic       locked,
  output logic       frame_tick,
  output logic [9:0] h_total,
  output logic [9:0] h_pulse,
  output logic [9:0] v_total,
  output logic [7:0] err_cnt
`ifdef SYNC_MON_COLOR_CHECK_EN
  ,
  output logic       color_err
`endif
);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_MEASURE,
    ST_LOCKED,
    ST_LOST
  } state_e;

  localparam logic [9:0]           EXP_H   = 10'(EXP_H_TOTAL);
  localparam logic [9:0]           EXP_V   = 10'(EXP_V_TOTAL);
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX ^ TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = TIMEOUT_W'(1);

  // Two-stage input pipeline; sync stages idle high.
  logic hs_a_q, hs_a_d, hs_b_q, hs_b_d;
  logic vs_a_q, vs_a_d, vs_b_q, vs_b_d;

  // Measurement datapath.
  logic [9:0]           h_cnt_q, h_cnt_d;
  logic [9:0]           h_lo_q, h_lo_d;
  logic [9:0]           line_cnt_q, line_cnt_d;
  logic [9:0]           h_total_q, h_total_d;
  logic [9:0]           h_pulse_q, h_pulse_d;
  logic [9:0]           v_total_q, v_total_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 qual_q, qual_d;        // first hs_fall seen
  logic                 frame_bad_q, frame_bad_d;
  logic                 frame_tick_q, frame_tick_d;

  // Lock FSM.
  state_e     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Events and qualifiers.
  logic hs_fall, hs_rise, vs_fall;
  logic wd_hit, hs_bad, frame_good;

  always_comb begin
    hs_fall = hs_b_q & ~hs_a_q;
    hs_rise = ~hs_b_q & hs_a_q;
    vs_fall = vs_b_q & ~vs_a_q;
    // Single-cycle timeout pulse: the watchdog then parks at WD_MAX so the
    // qualifier is only cleared once per loss of vsync.
    wd_hit  = !vs_fall && (wdog_q == WD_LAST);
    hs_bad  = hs_fall && qual_q && (h_cnt_q != EXP_H);
    // An hs_fall coinciding with vs_fall closes the last line of the old
    // frame, so its h_cnt verdict belongs to the frame being judged.
    frame_good = qual_q && !frame_bad_q && !hs_bad && (line_cnt_q == EXP_V);
  end

  // Datapath next-state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    hs_a_d       = hsync;
    hs_b_d       = hs_a_q;
    vs_a_d       = vsync;
    vs_b_d       = vs_a_q;
    h_cnt_d      = h_cnt_q;
    h_lo_d       = h_lo_q;
    line_cnt_d   = line_cnt_q;
    h_total_d    = h_total_q;
    h_pulse_d    = h_pulse_q;
    v_total_d    = v_total_q;
    wdog_d       = wdog_q;
    qual_d       = qual_q;
    frame_bad_d  = frame_bad_q;
    frame_tick_d = vs_fall;

    if (hs_fall) begin
      h_cnt_d   = 10'd1;
      h_total_d = h_cnt_q;
    end else if (h_cnt_q != 10'h3ff) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    // The fall cycle itself is the first low cycle, hence load with 1.
    if (hs_fall) begin
      h_lo_d = 10'd1;
    end else if (!hs_a_q && (h_lo_q != 10'h3ff)) begin
      h_lo_d = h_lo_q + 10'd1;
    end
    if (hs_rise) begin
      h_pulse_d = h_lo_q;
    end

    if (vs_fall) begin
      v_total_d  = line_cnt_q;
      line_cnt_d = hs_fall ? 10'd1 : 10'd0;
    end else if (hs_fall && (line_cnt_q != 10'h3ff)) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end

    if (vs_fall) begin
      wdog_d      = '0;
      frame_bad_d = 1'b0;
    end else begin
      frame_bad_d = frame_bad_q | hs_bad;
      if (wdog_q != WD_MAX) begin
        wdog_d = wdog_q + WD_ONE;
      end
    end

    if (wd_hit) begin
      qual_d = 1'b0;
    end else if (hs_fall) begin
      qual_d = 1'b1;
    end
  end

  // Lock FSM next-state.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      ST_ACQUIRE: begin
        if (vs_fall) begin
          state_d    = ST_MEASURE;
          good_cnt_d = 4'd0;
        end
      end
      ST_MEASURE: begin
        if (vs_fall) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_N) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (hs_bad || (vs_fall && !frame_good)) begin
          state_d = ST_LOST;
          if (err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      ST_LOST: begin
        if (vs_fall) begin
          state_d    = ST_MEASURE;
          good_cnt_d = 4'd0;
        end
      end
      default: state_d = ST_ACQUIRE;
    endcase

    if (wd_hit) begin
      state_d = ST_ACQUIRE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hs_a_q       <= 1'b1;
      hs_b_q       <= 1'b1;
      vs_a_q       <= 1'b1;
      vs_b_q       <= 1'b1;
      h_cnt_q      <= '0;
      h_lo_q       <= '0;
      line_cnt_q   <= '0;
      h_total_q    <= '0;
      h_pulse_q    <= '0;
      v_total_q    <= '0;
      wdog_q       <= '0;
      qual_q       <= 1'b0;
      frame_bad_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      state_q      <= ST_ACQUIRE;
      good_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      hs_a_q       <= hs_a_d;
      hs_b_q       <= hs_b_d;
      vs_a_q       <= vs_a_d;
      vs_b_q       <= vs_b_d;
      h_cnt_q      <= h_cnt_d;
      h_lo_q       <= h_lo_d;
      line_cnt_q   <= line_cnt_d;
      h_total_q    <= h_total_d;
      h_pulse_q    <= h_pulse_d;
      v_total_q    <= v_total_d;
      wdog_q       <= wdog_d;
      qual_q       <= qual_d;
      frame_bad_q  <= frame_bad_d;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign frame_tick = frame_tick_q;
  assign h_total    = h_total_q;
  assign h_pulse    = h_pulse_q;
  assign v_total    = v_total_q;
  assign err_cnt    = err_cnt_q;

`ifdef SYNC_MON_COLOR_CHECK_EN
  // Colour stage A resets to all-off so reset itself cannot flag an overlap.
  logic [2:0] rgb_a_q, rgb_a_d;
  logic       color_err_q, color_err_d;

  always_comb begin
    rgb_a_d     = {red, green, blue};
    color_err_d = color_err_q
                | (rgb_a_q[2] & rgb_a_q[1])
                | (rgb_a_q[2] & rgb_a_q[0])
                | (rgb_a_q[1] & rgb_a_q[0]);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rgb_a_q     <= '0;
      color_err_q <= 1'b0;
    end else begin
      rgb_a_q     <= rgb_a_d;
      color_err_q <= color_err_d;
    end
  end

  assign color_err = color_err_q;
`else
  logic unused_colour;
  assign unused_colour = ^{red, green, blue};
`endif

endmodule
